// File: rtl/uart_rx.sv
// uart_rx: UART receiver (8 data bits, 1 or 2 stop bits) feeding an 8-entry first-word-fall-through FIFO.
// Optional macro UART_RX_SYNC_EN puts a 2-flop synchronizer on rxd_pin_i; default build registers it once.
module uart_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd_pin_i,
  input  logic        rx_fifo_read_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_fifo_empty_o,
  output logic        rx_fifo_mark_o,
  input  logic [2:0]  rx_watermark_i,
  input  logic        rx_en_i,
  input  logic        two_stop_bits_i,
  input  logic [15:0] baud_rate_i,
  input  logic        err_clr_i,
  output logic        frame_err_o,
  output logic        overrun_err_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------- line conditioning ----------------
  logic line;

`ifdef UART_RX_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= rxd_pin_i;
      sync_q2 <= sync_q1;
    end
  end

  assign line = sync_q2;
`else
  logic rxd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxd_q <= 1'b1;
    else        rxd_q <= rxd_pin_i;
  end

  assign line = rxd_q;
`endif

  logic line_prev;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_prev <= 1'b1;
    else        line_prev <= line;
  end

  assign fall = line_prev & ~line;

  // ---------------- receive FSM ----------------
  state_t      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        two_stop_q, two_stop_d;
  logic        stop2_q, stop2_d;
  logic        tick;
  logic        fifo_wr;
  logic        frame_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
    end
  end

  assign tick = (baud_cnt_q == 16'd0);

  // baud_rate_i is only consulted on a reload, so mid-frame changes apply to the next bit period.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    fifo_wr    = 1'b0;
    frame_set  = 1'b0;

    if (state_q == IDLE) begin
      if (rx_en_i && fall) begin
        state_d    = START;
        baud_cnt_d = baud_rate_i >> 1;
      end
    end else if (!rx_en_i) begin
      state_d = IDLE;
    end else begin
      baud_cnt_d = tick ? baud_rate_i : (baud_cnt_q - 16'd1);
      if (tick) begin
        case (state_q)
          START: begin
            if (line) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              bit_cnt_d  = 4'd8;
              two_stop_d = two_stop_bits_i;
            end
          end
          DATA: begin
            shift_d   = {line, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q - 4'd1;
            if (bit_cnt_q == 4'd1) begin
              state_d = STOP;
              stop2_d = two_stop_q;
            end
          end
          STOP: begin
            if (!line) begin
              frame_set = 1'b1;
              state_d   = IDLE;
            end else if (stop2_q) begin
              stop2_d = 1'b0;
            end else begin
              fifo_wr = 1'b1;
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dbg_state = state_q;

  // ---------------- FIFO ----------------
  logic [7:0] mem [8];
  logic [2:0] wr_ptr_q;
  logic [2:0] rd_ptr_q;
  logic [3:0] count_q;
  logic       full;
  logic       rd_ok;
  logic       wr_ok;
  logic       overrun_set;
  logic       mark_q;
  logic       frame_err_q;
  logic       overrun_err_q;

  assign full        = (count_q == 4'd8);
  assign rd_ok       = rx_fifo_read_i && (count_q != 4'd0);
  // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign wr_ok       = fifo_wr && (!full || rd_ok);
  assign overrun_set = fifo_wr && full && !rd_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      mark_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 3'd1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
      mark_q <= (count_q > {1'b0, rx_watermark_i});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (frame_set)      frame_err_q <= 1'b1;
      else if (err_clr_i) frame_err_q <= 1'b0;
      if (overrun_set)    overrun_err_q <= 1'b1;
      else if (err_clr_i) overrun_err_q <= 1'b0;
    end
  end

  assign rx_data_o       = mem[rd_ptr_q];
  assign rx_fifo_empty_o = (count_q == 4'd0);
  assign rx_fifo_mark_o  = mark_q;
  assign frame_err_o     = frame_err_q;
  assign overrun_err_o   = overrun_err_q;

endmodule
